// File: rtl/uart_rx_controller.sv
// rtl/uart_rx_controller.sv - oversampled UART receiver with single-entry ack handshake
// Start bit is confirmed at its midpoint; data/stop bits are sampled one bit period apart from there.
module uart_rx_controller #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 budclk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 uart_rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic                 rx_meta;
  logic                 rx_s;
  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [SW-1:0]        sample_cnt;
  logic [SW-1:0]        sample_nxt;
  logic [BW-1:0]        bit_cnt;
  logic [BW-1:0]        bit_nxt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_nxt;
  logic [DATA_BITS:0]   shift_ext;
  logic                 load;
  logic                 fe_nxt;

  always_ff @(posedge budclk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  assign shift_ext = {rx_s, shift};

  always_comb begin
    state_nxt  = state;
    sample_nxt = sample_cnt;
    bit_nxt    = bit_cnt;
    shift_nxt  = shift;
    load       = 1'b0;
    fe_nxt     = 1'b0;
    if (!enable) begin
      state_nxt  = IDLE;
      sample_nxt = '0;
      bit_nxt    = '0;
      shift_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt  = START;
            sample_nxt = '0;
          end
        end
        START: begin
          if (sample_cnt == HALF_LAST) begin
            sample_nxt = '0;
            bit_nxt    = '0;
            state_nxt  = rx_s ? IDLE : DATA;
          end else begin
            sample_nxt = sample_cnt + 1'b1;
          end
        end
        DATA: begin
          if (sample_cnt == BIT_LAST) begin
            sample_nxt = '0;
            // LSB arrives first, so new bits enter at the top and walk down
            shift_nxt  = shift_ext[DATA_BITS:1];
            if (bit_cnt == DATA_LAST) begin
              bit_nxt   = '0;
              state_nxt = STOP;
            end else begin
              bit_nxt = bit_cnt + 1'b1;
            end
          end else begin
            sample_nxt = sample_cnt + 1'b1;
          end
        end
        STOP: begin
          if (sample_cnt == BIT_LAST) begin
            sample_nxt = '0;
            if (rx_s) begin
              load      = 1'b1;
              state_nxt = IDLE;
            end else begin
              fe_nxt    = 1'b1;
              state_nxt = WAIT_HIGH;
            end
          end else begin
            sample_nxt = sample_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // a break holds the line low; only a return to idle re-arms start detection
          if (rx_s) state_nxt = IDLE;
        end
        default: begin
          state_nxt  = IDLE;
          sample_nxt = '0;
          bit_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge budclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      sample_cnt <= sample_nxt;
      bit_cnt    <= bit_nxt;
      shift      <= shift_nxt;
      busy       <= (state_nxt != IDLE);
      frame_err  <= fe_nxt;
    end
  end

  // an ack landing on the load edge frees the slot, so the new byte is taken
  always_ff @(posedge budclk or posedge reset) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (load) begin
      if (!rx_valid || rx_ack) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (rx_ack && rx_valid) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// tb/tb_uart_rx_controller.sv - random and directed frames against a frame-timing reference model
module tb_uart_rx_controller;

  localparam int OS    = 16;
  localparam int DB    = 8;
  localparam int FRAME = (DB + 2) * OS;
  localparam int LAT   = OS / 2 + (DB + 1) * OS;
  localparam int M_IDLE = 0;
  localparam int M_RX   = 1;
  localparam int M_WAIT = 2;

  logic          budclk;
  logic          reset;
  logic          enable;
  logic          uart_rx;
  logic          rx_ack;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          busy;
  logic          frame_err;
  logic          overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fe_count = 0;
  int busy_cycles = 0;
  int busy_rise = 0;
  int valid_rise = 0;
  logic prev_busy = 1'b0;
  logic prev_valid = 1'b0;

  // reference model state: timing measured in edges since start detection
  logic          m_s1, m_s2;
  int            m_mode, m_t;
  logic [DB-1:0] m_bits, m_data;
  logic          m_valid, m_ovr, m_fe, m_busy;

  uart_rx_controller #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .budclk   (budclk),
    .reset    (reset),
    .enable   (enable),
    .uart_rx  (uart_rx),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial budclk = 1'b0;
  always #5 budclk = ~budclk;

  function automatic logic [DB+3:0] outs();
    return {rx_data, rx_valid, busy, frame_err, overrun};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin : model
    logic ls;
    logic load;
    int   n;
    forever begin
      @(posedge budclk or posedge reset);
      if (reset) begin
        m_s1 = 1'b1; m_s2 = 1'b1; m_mode = M_IDLE; m_t = 0; m_bits = '0;
        m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_fe = 1'b0; m_busy = 1'b0;
      end else begin
        ls = m_s2; m_s2 = m_s1; m_s1 = uart_rx;
        m_fe = 1'b0;
        load = 1'b0;
        if (!enable) m_mode = M_IDLE;
        else if (m_mode == M_IDLE) begin
          if (!ls) begin m_mode = M_RX; m_t = 0; end
        end else if (m_mode == M_RX) begin
          m_t++;
          if (m_t == OS / 2) begin
            if (ls) m_mode = M_IDLE;
          end else if (m_t > OS / 2 && (m_t - OS / 2) % OS == 0) begin
            n = (m_t - OS / 2) / OS;
            if (n <= DB) m_bits[n-1] = ls;
            else if (ls) begin load = 1'b1; m_mode = M_IDLE; end
            else begin m_fe = 1'b1; m_mode = M_WAIT; end
          end
        end else if (ls) m_mode = M_IDLE;
        if (load) begin
          if (!m_valid || rx_ack) begin m_data = m_bits; m_valid = 1'b1; end
          else m_ovr = 1'b1;
        end else if (rx_ack && m_valid) begin
          m_valid = 1'b0; m_ovr = 1'b0;
        end
        m_busy = (m_mode != M_IDLE);
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge budclk);
      cyc++;
      check("cycle", 32'(outs()), 32'({m_data, m_valid, m_busy, m_fe, m_ovr}));
      if (frame_err) fe_count++;
      if (busy) busy_cycles++;
      if (busy && !prev_busy) busy_rise = cyc;
      if (rx_valid && !prev_valid) valid_rise = cyc;
      prev_busy = busy;
      prev_valid = rx_valid;
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge budclk);
      uart_rx = 1'b1;
      rx_ack  = 1'b0;
    end
  endtask

  task automatic ack_pulse();
    @(negedge budclk); rx_ack = 1'b1;
    @(negedge budclk); rx_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic stop_bit, input int ack_j,
                            input bit noise, input int drop_j, input int drop_len, input int n_cyc);
    logic [DB+1:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int j = 0; j < n_cyc; j++) begin
      @(negedge budclk);
      uart_rx = fr[j / OS];
      if (ack_j >= 0) rx_ack = (j == ack_j);
      else if (noise) rx_ack = ($urandom_range(0, 19) == 0);
      else rx_ack = 1'b0;
      if (j == drop_j) enable = 1'b0;
      else if (j == drop_j + drop_len) enable = 1'b1;
    end
    rx_ack = 1'b0;
    enable = 1'b1;
  endtask

  initial begin : stim
    int b0, fe0;
    reset = 1'b1; enable = 1'b1; uart_rx = 1'b1; rx_ack = 1'b0;
    repeat (3) @(negedge budclk);
    check("reset_state", 32'(outs()), 32'(0));
    reset = 1'b0;
    idle_cycles(5);

    send_frame(8'hA5, 1'b1, -1, 0, -1, 0, FRAME);
    check("a5_outputs", 32'(outs()), 32'({8'hA5, 1'b1, 1'b0, 1'b0, 1'b0}));
    check("a5_latency", 32'(valid_rise - busy_rise), 32'(LAT));
    ack_pulse();
    check("a5_acked", 32'(rx_valid), 32'(0));

    idle_cycles(5);
    b0 = busy_cycles; fe0 = fe_count;
    send_frame(8'h00, 1'b1, -1, 0, -1, 0, 4);
    idle_cycles(20);
    check("glitch_busy_cycles", 32'(busy_cycles - b0), 32'(OS / 2));
    check("glitch_outputs", 32'({rx_valid, busy, fe_count - fe0}), 32'(0));

    fe0 = fe_count;
    send_frame(8'h3C, 1'b0, -1, 0, -1, 0, FRAME);
    repeat (40) begin @(negedge budclk); uart_rx = 1'b0; end
    check("break_frame_err_pulses", 32'(fe_count - fe0), 32'(1));
    check("break_wait_high", 32'({rx_valid, busy}), 32'(2'b01));
    idle_cycles(5);
    check("break_released", 32'(busy), 32'(0));

    send_frame(8'h11, 1'b1, -1, 0, -1, 0, FRAME);
    idle_cycles(3);
    send_frame(8'h22, 1'b1, -1, 0, -1, 0, FRAME);
    check("overrun_set", 32'({rx_data, rx_valid, overrun}), 32'({8'h11, 1'b1, 1'b1}));
    ack_pulse();
    check("overrun_cleared", 32'({rx_valid, overrun}), 32'(0));

    idle_cycles(3);
    send_frame(8'h11, 1'b1, -1, 0, -1, 0, FRAME);
    idle_cycles(3);
    send_frame(8'h22, 1'b1, LAT + 2, 0, -1, 0, FRAME);
    check("ack_on_load", 32'({rx_data, rx_valid, overrun}), 32'({8'h22, 1'b1, 1'b0}));

    idle_cycles(3);
    send_frame(8'h96, 1'b1, -1, 0, -1, 0, OS * 4 + OS / 2);
    check("mid_frame_busy", 32'(busy), 32'(1));
    @(negedge budclk);
    #2 reset = 1'b1; uart_rx = 1'b1;
    #1 check("async_reset", 32'(outs()), 32'(0));
    @(negedge budclk); reset = 1'b0;
    idle_cycles(10);
    check("after_reset_idle", 32'(outs()), 32'(0));

    send_frame(8'h5A, 1'b1, -1, 0, -1, 0, FRAME);
    idle_cycles(3);
    send_frame(8'h81, 1'b1, -1, 0, -1, 0, OS * 4 + OS / 2);
    @(negedge budclk); enable = 1'b0;
    @(negedge budclk);
    check("enable_abort", 32'(outs()), 32'({8'h5A, 1'b1, 1'b0, 1'b0, 1'b0}));
    uart_rx = 1'b1; enable = 1'b1;
    idle_cycles(20);
    check("enable_retained", 32'({rx_data, rx_valid, busy}), 32'({8'h5A, 1'b1, 1'b0}));
    ack_pulse();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        send_frame(8'h00, 1'b1, -1, 0, -1, 0, $urandom_range(1, 6));
        idle_cycles(OS);
      end
      send_frame(DB'($urandom), ($urandom_range(0, 5) != 0), -1, 1,
                 ($urandom_range(0, 7) == 0) ? $urandom_range(5, 150) : -1,
                 $urandom_range(1, 3), FRAME);
      idle_cycles($urandom_range(0, 12));
    end
    idle_cycles(FRAME + 10);
    ack_pulse();
    idle_cycles(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
